jtag_frame_assembler: RTL and testbench
=======================================

Name: jtag_frame_assembler

Overview:
- Parametrised successor to the fixed 2-burst, 14x32-bit JTAG image loader in the top level.
- Collects WORDS_PER_BURST words per NEXT handshake and assembles them into a FRAME_BITS-wide frame.
- Closes the frame on FINISH or when the frame is full, then issues a one-cycle start pulse to the SNN only when the network is idle.
- Sits between the JTAG mailbox (MyDesign outputs) and run_network.

Parameters:
- WORD_W, 32, bits per mailbox word.
- WORDS_PER_BURST, 14, words delivered per NEXT handshake.
- FRAME_BITS, 800, frame width presented to the SNN.
- Derived: BURST_BITS = WORD_W*WORDS_PER_BURST; MAX_BURSTS = ceil(FRAME_BITS/BURST_BITS) (2 at defaults); IDX_W = clog2(MAX_BURSTS+1).

Ports:
- iCLK, in, 1, single clock (wCLK120 domain).
- iRESETn, in, 1, asynchronous active-low reset.
- iBURST_DATA, in, BURST_BITS, flattened mailbox words; word k occupies bits [k*WORD_W +: WORD_W].
- iNEXT, in, 1, level from mailbox; a rising edge marks one valid burst.
- iFINISH, in, 1, sampled at the iNEXT rising edge; 1 means this is the last burst of the frame.
- iSNN_BUSY, in, 1, SNN still processing the previous frame.
- iCLR_ERR, in, 1, clears oERR_DROP.
- oFRAME, out, FRAME_BITS, assembled frame.
- oFRAME_VALID, out, 1, frame complete and stable.
- oSTART, out, 1, one-cycle start pulse to the SNN.
- oBURST_ACK, out, 1, one-cycle pulse per accepted burst.
- oBURST_IDX, out, IDX_W, number of bursts accepted into the current frame.
- oERR_DROP, out, 1, sticky flag: a burst was discarded.

Behaviour:
- Reset (asynchronous, iRESETn=0):
  - All outputs are 0: oFRAME, oFRAME_VALID, oSTART, oBURST_ACK, oBURST_IDX, oERR_DROP.
  - nxt_q=0, state=IDLE.
  - Reset mid-frame discards partial data. There is no recovery of a partial frame.
- Edge detect: nxt_q registers iNEXT. A burst event occurs in cycle N when iNEXT=1 and nxt_q=0. A held-high iNEXT produces exactly one event.
- States:
  - IDLE: idx=0.
  - COLLECT: 0 < idx < MAX_BURSTS.
  - PEND: frame complete, waiting for SNN.
  - FIRE: oSTART=1.
- Burst accept (in IDLE or COLLECT):
  - Bits [idx*BURST_BITS +: BURST_BITS] are written, clipped at FRAME_BITS-1. Excess words of the final burst are ignored.
  - In IDLE, the whole oFRAME is cleared to 0 before the write, so short frames have zero-filled tails.
  - idx increments.
  - oBURST_ACK=1 in cycle N+1, with the updated oFRAME and oBURST_IDX visible in N+1.
- Frame completion:
  - Occurs if iFINISH=1 at the event, or if idx+1 == MAX_BURSTS; next state is PEND. Otherwise next state is COLLECT.
  - FINISH on the first burst is legal and completes a 1-burst frame.
  - Completion without FINISH, at the MAX_BURSTS limit, is legal and not an error.
- PEND:
  - oFRAME_VALID=1.
  - If iSNN_BUSY=0, go to FIRE; otherwise stay.
- FIRE:
  - oSTART=1 for exactly one cycle, then go to IDLE with idx=0.
  - oFRAME and oFRAME_VALID hold until the next accepted burst.
  - Latency: a completing event in cycle N gives oSTART in cycle N+2 when not busy.
- Drop:
  - A burst event in PEND or FIRE is discarded: oERR_DROP=1 (sticky), no ack, no data change.
  - iCLR_ERR=1 clears the flag next cycle. If iCLR_ERR coincides with a new drop, the drop wins and the flag stays 1.
- iSNN_BUSY toggling in COLLECT has no effect.
- oFRAME never changes while oFRAME_VALID=1 and oSTART has not yet fired.

Optional Feature:
- Macro: FRAME_DBUF_EN.
- Defined:
  - A staging buffer receives bursts and oFRAME becomes a separate output buffer.
  - On completion, staging is copied into oFRAME when the output is free (state not PEND/FIRE awaiting start). Collection of frame k+1 continues into staging while frame k is pending.
  - A drop occurs only when staging is complete and the output buffer is still pending.
  - The cost is one extra FRAME_BITS register.
- Undefined: single buffer, with behaviour exactly as above.

Test Plan:
1. Defaults, iSNN_BUSY=0. Two bursts (0xA5A5A5A5 in every word, then 0x3C3C3C3C), FINISH on the second:
   - Expected oFRAME[447:0] all A5 pattern and oFRAME[799:448] = 0x3C pattern (11 words).
   - Expected oBURST_ACK twice, oSTART one cycle exactly 2 cycles after the second event, oBURST_IDX=2.
2. Single burst of 0xFFFFFFFF with FINISH=1, after a previous full frame:
   - Expected oFRAME[447:0] all 1s and oFRAME[799:448] = 0.
   - Expected oSTART pulses once.
3. Two bursts without FINISH:
   - Expected auto-complete, oSTART once, oERR_DROP=0.
4. iSNN_BUSY=1 at completion, held for 20 cycles:
   - Expected oFRAME_VALID=1 and no oSTART for 20 cycles, then oSTART 1 cycle after busy falls.
   - A third burst during the wait sets oERR_DROP=1 and leaves oFRAME unchanged.
   - iCLR_ERR clears the flag.
5. iNEXT held high for 50 cycles:
   - Expected exactly one oBURST_ACK.
6. iRESETn pulsed low after the first burst of a frame:
   - Expected all outputs 0 immediately (asynchronous).
   - A subsequent 2-burst frame assembles correctly with oBURST_IDX counting from 1.

Source files
------------

// File: rtl/jtag_frame_if.sv
// Mailbox-side and SNN-side signals of the JTAG frame assembler.
// master = mailbox/SNN environment, slave = the assembler.
interface jtag_frame_if #(
   parameter int WORD_W          = 32,
   parameter int WORDS_PER_BURST = 14,
   parameter int FRAME_BITS      = 800
);
   localparam int BURST_BITS = WORD_W * WORDS_PER_BURST;
   localparam int MAX_BURSTS = (FRAME_BITS + BURST_BITS - 1) / BURST_BITS;
   localparam int IDX_W      = $clog2(MAX_BURSTS + 1);

   logic [BURST_BITS-1:0] iBURST_DATA;
   logic                  iNEXT;
   logic                  iFINISH;
   logic                  iSNN_BUSY;
   logic                  iCLR_ERR;
   logic [FRAME_BITS-1:0] oFRAME;
   logic                  oFRAME_VALID;
   logic                  oSTART;
   logic                  oBURST_ACK;
   logic [IDX_W-1:0]      oBURST_IDX;
   logic                  oERR_DROP;

   modport master (
      output iBURST_DATA, iNEXT, iFINISH, iSNN_BUSY, iCLR_ERR,
      input  oFRAME, oFRAME_VALID, oSTART, oBURST_ACK, oBURST_IDX, oERR_DROP
   );
   modport slave (
      input  iBURST_DATA, iNEXT, iFINISH, iSNN_BUSY, iCLR_ERR,
      output oFRAME, oFRAME_VALID, oSTART, oBURST_ACK, oBURST_IDX, oERR_DROP
   );
endinterface

// File: rtl/jtag_frame_assembler.sv
// Assembles mailbox bursts into a FRAME_BITS frame and issues a start pulse when the SNN is idle.
// Define FRAME_DBUF_EN for a staging buffer that keeps collecting while a frame waits for the SNN.
module jtag_frame_assembler #(
   parameter int WORD_W          = 32,
   parameter int WORDS_PER_BURST = 14,
   parameter int FRAME_BITS      = 800
) (
   input logic         iCLK,
   input logic         iRESETn,
   jtag_frame_if.slave bus
);
   localparam int BURST_BITS = WORD_W * WORDS_PER_BURST;
   localparam int MAX_BURSTS = (FRAME_BITS + BURST_BITS - 1) / BURST_BITS;
   localparam int IDX_W      = $clog2(MAX_BURSTS + 1);

   typedef enum logic [1:0] {IDLE, COLLECT, PEND, FIRE} state_t;

   state_t                state_q, state_d;
   logic                  nxt_q;
   logic [IDX_W-1:0]      idx_q, idx_d, idx_base, idx_inc;
   logic [FRAME_BITS-1:0] frame_q, frame_d, asm_base, asm_frame;
   logic                  valid_q, valid_d, ack_q, ack_d, err_q, err_d;
   logic                  evt, drop, done;
`ifdef FRAME_DBUF_EN
   logic [FRAME_BITS-1:0] stg_q, stg_d;
   logic                  full_q, full_d, xfer;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      frame_d  = frame_q;
      valid_d  = valid_q;
      ack_d    = 1'b0;
      drop     = 1'b0;
      evt      = bus.iNEXT & ~nxt_q;
`ifdef FRAME_DBUF_EN
      stg_d    = stg_q;
      // Output buffer free: a completed staging frame moves out this cycle.
      xfer     = full_q && (state_q != PEND) && (state_q != FIRE);
      full_d   = full_q & ~xfer;
      idx_base = xfer ? '0 : idx_q;
      asm_base = (idx_base == '0) ? '0 : stg_q;
`else
      idx_base = idx_q;
      asm_base = (state_q == IDLE) ? '0 : frame_q;
`endif
      // Burst idx lands at bit idx*BURST_BITS; bits past FRAME_BITS fall off.
      asm_frame = asm_base;
      for (int j = 0; j < FRAME_BITS; j++)
         if ((j / BURST_BITS) == int'(idx_base))
            asm_frame[j] = bus.iBURST_DATA[j % BURST_BITS];
      idx_inc = idx_base + IDX_W'(1);
      done    = bus.iFINISH || (idx_inc == IDX_W'(MAX_BURSTS));

`ifdef FRAME_DBUF_EN
      idx_d = idx_base;
      if (evt) begin
         if (full_d) drop = 1'b1;
         else begin
            stg_d  = asm_frame;
            idx_d  = idx_inc;
            ack_d  = 1'b1;
            full_d = done;
         end
      end
      case (state_q)
         PEND:    if (!bus.iSNN_BUSY) state_d = FIRE;
         FIRE:    state_d = IDLE;
         default: if (xfer) begin
            frame_d = stg_q;
            valid_d = 1'b1;
            state_d = PEND;
         end
      endcase
`else
      case (state_q)
         IDLE, COLLECT: if (evt) begin
            frame_d = asm_frame;
            idx_d   = idx_inc;
            ack_d   = 1'b1;
            valid_d = done;
            state_d = done ? PEND : COLLECT;
         end
         PEND: begin
            drop = evt;
            if (!bus.iSNN_BUSY) state_d = FIRE;
         end
         default: begin
            drop    = evt;
            idx_d   = '0;
            state_d = IDLE;
         end
      endcase
`endif
      // A drop in the same cycle as a clear keeps the flag set.
      err_d = drop | (err_q & ~bus.iCLR_ERR);
   end

   always_ff @(posedge iCLK or negedge iRESETn) begin
      if (!iRESETn) begin
         state_q <= IDLE;
         nxt_q   <= 1'b0;
         idx_q   <= '0;
         frame_q <= '0;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef FRAME_DBUF_EN
         stg_q   <= '0;
         full_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         nxt_q   <= bus.iNEXT;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         valid_q <= valid_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
`ifdef FRAME_DBUF_EN
         stg_q   <= stg_d;
         full_q  <= full_d;
`endif
      end
   end

   assign bus.oFRAME       = frame_q;
   assign bus.oFRAME_VALID = valid_q;
   assign bus.oSTART       = (state_q == FIRE);
   assign bus.oBURST_ACK   = ack_q;
   assign bus.oBURST_IDX   = idx_q;
   assign bus.oERR_DROP    = err_q;
endmodule

// File: tb/tb_jtag_frame_assembler.sv
// Scoreboard bench for jtag_frame_assembler: a word-list model predicts acks and start frames.
module tb_jtag_frame_assembler;
   localparam int WORD_W = 32;
   localparam int WPB    = 14;
   localparam int FB     = 800;
   localparam int BB     = WORD_W * WPB;
   localparam int MAXB   = (FB + BB - 1) / BB;
   localparam int FW     = FB / WORD_W;

   typedef logic [FB-1:0] frame_t;
   typedef logic [BB-1:0] burst_t;
   typedef struct {frame_t frame; int idx;} ack_t;

   logic iCLK = 1'b0;
   logic iRESETn = 1'b0;
   always #5 iCLK = ~iCLK;

   jtag_frame_if #(.WORD_W(WORD_W), .WORDS_PER_BURST(WPB), .FRAME_BITS(FB)) bus();
   jtag_frame_assembler #(.WORD_W(WORD_W), .WORDS_PER_BURST(WPB), .FRAME_BITS(FB)) dut (
      .iCLK(iCLK), .iRESETn(iRESETn), .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   int ack_cnt = 0;
   ack_t   exp_ack[$];
   frame_t exp_start[$];

   // Model: the frame is simply the list of words received so far, zero padded.
   logic [WORD_W-1:0] m_words[$];
   int     m_cnt  = 0;
   bit     m_pend = 0;
   bit     m_err  = 0;
   frame_t m_last = '0;

   task automatic check(input string name, input frame_t act, input frame_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   function automatic frame_t pack_frame();
      frame_t f = '0;
      for (int i = 0; i < m_words.size() && i < FW; i++) f[i*WORD_W +: WORD_W] = m_words[i];
      return f;
   endfunction

   function automatic burst_t rep(input logic [WORD_W-1:0] w);
      burst_t d;
      for (int k = 0; k < WPB; k++) d[k*WORD_W +: WORD_W] = w;
      return d;
   endfunction

   function automatic burst_t rnd_burst();
      burst_t d;
      for (int k = 0; k < WPB; k++) d[k*WORD_W +: WORD_W] = $urandom;
      return d;
   endfunction

   task automatic model_event(input burst_t d, input bit fin);
      frame_t f;
      if (m_pend) begin
         m_err = 1;
         return;
      end
      for (int k = 0; k < WPB; k++) m_words.push_back(d[k*WORD_W +: WORD_W]);
      m_cnt++;
      f = pack_frame();
      exp_ack.push_back('{f, m_cnt});
      if (fin || m_cnt == MAXB) begin
         m_pend = 1;
         m_last = f;
         exp_start.push_back(f);
         m_words.delete();
         m_cnt = 0;
      end
   endtask

   task automatic model_reset();
      m_words.delete();
      m_cnt = 0; m_pend = 0; m_err = 0;
   endtask

   // One burst: iNEXT high for cycle N, low in N+1; returns at the N+1 sample point.
   task automatic burst(input burst_t d, input bit fin);
      @(negedge iCLK);
      bus.iBURST_DATA = d; bus.iFINISH = fin; bus.iNEXT = 1'b1;
      model_event(d, fin);
      @(negedge iCLK);
      bus.iNEXT = 1'b0; bus.iFINISH = 1'b0;
   endtask

   task automatic start_timing(input string tag);
      check({tag, "_start_n1"}, frame_t'(bus.oSTART), frame_t'(0));
      check({tag, "_valid_n1"}, frame_t'(bus.oFRAME_VALID), frame_t'(1));
      @(negedge iCLK);
      check({tag, "_start_n2"}, frame_t'(bus.oSTART), frame_t'(1));
      m_pend = 0;
      @(negedge iCLK);
      check({tag, "_start_n3"}, frame_t'(bus.oSTART), frame_t'(0));
   endtask

   // Monitor
   always @(negedge iCLK) begin
      ack_t e;
      frame_t s;
      if (iRESETn && bus.oBURST_ACK) begin
         ack_cnt++;
         if (exp_ack.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ack got=1 want=0");
         end else begin
            e = exp_ack.pop_front();
            check("ack_frame", bus.oFRAME, e.frame);
            check("ack_idx", frame_t'(bus.oBURST_IDX), frame_t'(e.idx));
         end
      end
      if (iRESETn && bus.oSTART) begin
         if (exp_start.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_start got=1 want=0");
         end else begin
            s = exp_start.pop_front();
            check("start_frame", bus.oFRAME, s);
            check("start_valid", frame_t'(bus.oFRAME_VALID), frame_t'(1));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, badc, a0;
      bit fin, last;
      bus.iBURST_DATA = '0; bus.iNEXT = 0; bus.iFINISH = 0;
      bus.iSNN_BUSY = 0; bus.iCLR_ERR = 0;
      #1;
      check("rst_frame", bus.oFRAME, '0);
      check("rst_valid", frame_t'(bus.oFRAME_VALID), frame_t'(0));
      check("rst_start", frame_t'(bus.oSTART), frame_t'(0));
      check("rst_ack", frame_t'(bus.oBURST_ACK), frame_t'(0));
      check("rst_idx", frame_t'(bus.oBURST_IDX), frame_t'(0));
      check("rst_err", frame_t'(bus.oERR_DROP), frame_t'(0));
      @(negedge iCLK); @(negedge iCLK);
      iRESETn = 1'b1;

      // Two patterned bursts, FINISH on the second
      burst(rep(32'hA5A5A5A5), 0);
      repeat (2) @(negedge iCLK);
      burst(rep(32'h3C3C3C3C), 1);
      start_timing("t1");

      // Single all-ones burst: tail must be zero
      repeat (2) @(negedge iCLK);
      burst(rep(32'hFFFFFFFF), 1);
      start_timing("t2");

      // Auto-complete at MAX_BURSTS without FINISH
      burst(rnd_burst(), 0);
      burst(rnd_burst(), 0);
      start_timing("t3");
      check("t3_err", frame_t'(bus.oERR_DROP), frame_t'(m_err));

      // SNN busy at completion, drop during the wait, then clear
      bus.iSNN_BUSY = 1;
      burst(rnd_burst(), 0);
      burst(rnd_burst(), 1);
      badc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge iCLK);
         if (!bus.oFRAME_VALID || bus.oSTART || bus.oFRAME !== m_last) badc++;
      end
      burst(rnd_burst(), 0);
      check("t4_drop_err", frame_t'(bus.oERR_DROP), frame_t'(m_err));
      check("t4_drop_frame", bus.oFRAME, m_last);
      for (int i = 0; i < 10; i++) begin
         @(negedge iCLK);
         if (!bus.oFRAME_VALID || bus.oSTART || bus.oFRAME !== m_last) badc++;
      end
      check("t4_wait_cycles", frame_t'(badc), frame_t'(0));
      @(negedge iCLK); bus.iCLR_ERR = 1;
      @(negedge iCLK); bus.iCLR_ERR = 0; m_err = 0;
      check("t4_clr_err", frame_t'(bus.oERR_DROP), frame_t'(m_err));
      bus.iSNN_BUSY = 0;
      @(negedge iCLK);
      check("t4_start", frame_t'(bus.oSTART), frame_t'(1));
      m_pend = 0;
      @(negedge iCLK);
      check("t4_start_end", frame_t'(bus.oSTART), frame_t'(0));

      // iNEXT held high for 50 cycles
      a0 = ack_cnt;
      @(negedge iCLK);
      bus.iBURST_DATA = rnd_burst(); bus.iFINISH = 0; bus.iNEXT = 1;
      model_event(bus.iBURST_DATA, 0);
      repeat (50) @(negedge iCLK);
      bus.iNEXT = 0;
      @(negedge iCLK);
      check("t5_one_ack", frame_t'(ack_cnt - a0), frame_t'(1));
      burst(rnd_burst(), 1);
      start_timing("t5");

      // Asynchronous reset mid-frame
      burst(rnd_burst(), 0);
      repeat (2) @(negedge iCLK);
      #2 iRESETn = 1'b0;
      #1;
      check("t6_frame", bus.oFRAME, '0);
      check("t6_valid", frame_t'(bus.oFRAME_VALID), frame_t'(0));
      check("t6_idx", frame_t'(bus.oBURST_IDX), frame_t'(0));
      check("t6_err_ack_start", frame_t'({bus.oERR_DROP, bus.oBURST_ACK, bus.oSTART}), frame_t'(0));
      model_reset();
      @(negedge iCLK);
      iRESETn = 1'b1;
      burst(rnd_burst(), 0);
      burst(rnd_burst(), 1);
      start_timing("t6");

      // Random frames; busy toggles freely while collecting
      for (int f = 0; f < 25; f++) begin
         nb = $urandom_range(1, MAXB);
         for (int b = 0; b < nb; b++) begin
            last = (b == nb - 1);
            fin  = last && (nb == 1 || $urandom_range(0, 1) == 1);
            bus.iSNN_BUSY = last ? 1'b0 : 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge iCLK);
            burst(rnd_burst(), fin);
         end
         start_timing("rnd");
         repeat (2) @(negedge iCLK);
      end

      repeat (5) @(negedge iCLK);
      check("ackq_empty", frame_t'(exp_ack.size()), frame_t'(0));
      check("startq_empty", frame_t'(exp_start.size()), frame_t'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
